// File: rtl/lpif_dstrm_flit_assembler.sv
// rtl/lpif_dstrm_flit_assembler.sv - gathers LPIF dstrm beats into flits with protid/CRC/error and queues them
module lpif_dstrm_flit_assembler #(
    parameter int BEATS_PER_FLIT = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk_wr,
    input  logic                          rst_wr,
    input  logic [3:0]                    dstrm_state,
    input  logic [1:0]                    dstrm_protid,
    input  logic [127:0]                  dstrm_data,
    input  logic                          dstrm_dvalid,
    input  logic [7:0]                    dstrm_crc,
    input  logic                          dstrm_crc_valid,
    input  logic                          dstrm_valid,
    output logic [128*BEATS_PER_FLIT-1:0] flit_data,
    output logic [1:0]                    flit_protid,
    output logic [7:0]                    flit_crc,
    output logic                          flit_err,
    output logic                          flit_valid,
    input  logic                          flit_ready,
    output logic                          link_active,
    output logic                          state_chg,
    output logic [7:0]                    ovf_cnt,
    output logic [7:0]                    frag_cnt,
    output logic                          err_sticky
);
    localparam int FW = 128 * BEATS_PER_FLIT;
    localparam int BW = $clog2(BEATS_PER_FLIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [3:0]    ST_ACTIVE = 4'h1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_FLIT - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [127:0]  asm_q [BEATS_PER_FLIT];
    logic [1:0]    protid_q;
    logic          err_q, err_d;
    logic [PW:0]   wr_q, rd_q;
    logic [FW-1:0] data_mem [FIFO_DEPTH];
    logic [1:0]    pid_mem  [FIFO_DEPTH];
    logic [7:0]    crc_mem  [FIFO_DEPTH];
    logic          err_mem  [FIFO_DEPTH];
    logic [7:0]    ovf_q, frag_q;
    logic [3:0]    state_q;
    logic          link_q, chg_q, sticky_q;

    logic          is_active, acc, last, pid_bad, crc_hit, drop_frag;
    logic          empty, full, pop, push_ok, ovf;
    logic          push_err;
    logic [7:0]    push_crc;
    logic [FW-1:0] push_data;

    always_comb begin
        is_active = dstrm_valid && (dstrm_state == ST_ACTIVE);
        acc       = is_active && dstrm_dvalid;
        last      = acc && (bcnt_q == LAST_BEAT);
        pid_bad   = acc && (bcnt_q != '0) && (dstrm_protid != protid_q);
        crc_hit   = dstrm_valid && dstrm_crc_valid;
        drop_frag = dstrm_valid && (dstrm_state != ST_ACTIVE) && (bcnt_q != '0);
        // A CRC is only legal on the accepted last beat; anything else taints the flit.
        push_err  = err_q || pid_bad || !crc_hit;
        push_crc  = crc_hit ? dstrm_crc : 8'h00;

        err_d = err_q || pid_bad || (crc_hit && !last);
        if (last || drop_frag) err_d = 1'b0;

        bcnt_d = bcnt_q;
        if (acc)            bcnt_d = last ? '0 : bcnt_q + BW'(1);
        else if (drop_frag) bcnt_d = '0;

        push_data = '0;
        for (int i = 0; i < BEATS_PER_FLIT - 1; i++) push_data[i*128 +: 128] = asm_q[i];
        push_data[(BEATS_PER_FLIT-1)*128 +: 128] = dstrm_data;

        empty   = (wr_q == rd_q);
        full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
        pop     = !empty && flit_ready;
        push_ok = last && (!full || pop);
        ovf     = last && full && !pop;
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            bcnt_q   <= '0;
            protid_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < BEATS_PER_FLIT; i++) asm_q[i] <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            err_q  <= err_d;
            if (acc) asm_q[bcnt_q] <= dstrm_data;
            if (acc && bcnt_q == '0) protid_q <= dstrm_protid;
        end
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pid_mem[i]  <= '0;
                crc_mem[i]  <= '0;
                err_mem[i]  <= 1'b0;
            end
        end else begin
            if (pop) rd_q <= rd_q + 1'b1;
            if (push_ok) begin
                data_mem[wr_q[PW-1:0]] <= push_data;
                pid_mem[wr_q[PW-1:0]]  <= protid_q;
                crc_mem[wr_q[PW-1:0]]  <= push_crc;
                err_mem[wr_q[PW-1:0]]  <= push_err;
                wr_q <= wr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            ovf_q    <= '0;
            frag_q   <= '0;
            state_q  <= '0;
            link_q   <= 1'b0;
            chg_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (ovf && ovf_q != 8'hFF)        ovf_q  <= ovf_q + 8'd1;
            if (drop_frag && frag_q != 8'hFF) frag_q <= frag_q + 8'd1;
            if (push_ok && push_err)          sticky_q <= 1'b1;
            state_q <= dstrm_state;
            chg_q   <= (dstrm_state != state_q);
            link_q  <= is_active;
        end
    end

    assign flit_data   = data_mem[rd_q[PW-1:0]];
    assign flit_protid = pid_mem[rd_q[PW-1:0]];
    assign flit_crc    = crc_mem[rd_q[PW-1:0]];
    assign flit_err    = err_mem[rd_q[PW-1:0]];
    assign flit_valid  = !empty;
    assign link_active = link_q;
    assign state_chg   = chg_q;
    assign ovf_cnt     = ovf_q;
    assign frag_cnt    = frag_q;
    assign err_sticky  = sticky_q;
endmodule
